// File: rtl/ka_seq_mult_ctrl.sv
// One-level Karatsuba GF(2)[x] multiplier sequencer: issues low, high and middle
// half-width products to a shared combinational carry-less multiplier, then overlap-XORs them.
module ka_seq_mult_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N/2-1:0] sub_a,
  output logic [N/2-1:0] sub_b,
  input  logic [N-2:0]   sub_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] p
);

  localparam int unsigned H  = N / 2;
  localparam int unsigned SW = 2 * H - 1;
  localparam int unsigned PW = 2 * N - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_MID,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [N-1:0]  a_q, b_q, a_next, b_next;
  logic [H-1:0]  sub_a_next, sub_b_next;
  logic [SW-1:0] p_lo, p_hi, mid;
  logic [PW-1:0] p_next;

  // Next state, operand capture, product combine, and the sub-operands for the
  // state being entered so that sub_a/sub_b come straight from flops.
  always_comb begin
    state_next = state;
    a_next     = a_q;
    b_next     = b_q;
    p_next     = p;
    sub_a_next = '0;
    sub_b_next = '0;
    mid        = sub_p ^ p_lo ^ p_hi;

    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
          state_next = S_LOW;
        end
      end
      S_LOW:  state_next = S_HIGH;
      S_HIGH: state_next = S_MID;
      S_MID: begin
        // sub_p carries the middle product this cycle
        p_next     = PW'(p_lo) ^ (PW'(mid) << H) ^ (PW'(p_hi) << N);
        state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    unique case (state_next)
      S_LOW: begin
        sub_a_next = a_next[H-1:0];
        sub_b_next = b_next[H-1:0];
      end
      S_HIGH: begin
        sub_a_next = a_next[N-1:H];
        sub_b_next = b_next[N-1:H];
      end
      S_MID: begin
        sub_a_next = a_next[H-1:0] ^ a_next[N-1:H];
        sub_b_next = b_next[H-1:0] ^ b_next[N-1:H];
      end
      default: begin
        sub_a_next = '0;
        sub_b_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_lo      <= '0;
      p_hi      <= '0;
      p         <= '0;
      sub_a     <= '0;
      sub_b     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      a_q       <= a_next;
      b_q       <= b_next;
      p         <= p_next;
      sub_a     <= sub_a_next;
      sub_b     <= sub_b_next;
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      if (state == S_LOW)  p_lo <= sub_p;
      if (state == S_HIGH) p_hi <= sub_p;
    end
  end

endmodule

// File: tb/tb_ka_seq_mult_ctrl.sv
// Bench for ka_seq_mult_ctrl at N=8 and N=16: directed cases, backpressure, mid-op
// reset, and randomized traffic against a bit-serial carry-less reference.
module tb_ka_seq_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit-serial carry-less multiply of two w-bit polynomials.
  function automatic logic [63:0] clmul(input logic [63:0] x, input logic [63:0] y, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      if (y[i]) r = r ^ (x << i);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int unsigned NN = (g == 0) ? 8 : 16;
    localparam int unsigned HH = NN / 2;
    localparam int unsigned SW = 2 * HH - 1;

    logic          rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [NN-1:0] a, b;
    logic [HH-1:0] sub_a, sub_b;
    logic [SW-1:0] sub_p;
    logic [2*NN-2:0] p;
    bit            fin = 1'b0;

    assign sub_p = SW'(clmul(64'(sub_a), 64'(sub_b), int'(HH)));

    ka_seq_mult_ctrl #(.N(NN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub_a(sub_a), .sub_b(sub_b), .sub_p(sub_p),
      .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    task automatic c(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk($sformatf("N%0d %s", NN, tag), got, exp);
    endtask

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic wait_out(input string tag);
      int k;
      k = 0;
      while (!out_valid && k < 12) begin
        step();
        k++;
      end
      c({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] exp, input string tag);
      a = NN'(av); b = NN'(bv); in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      wait_out(tag);
      c({tag, "_p"}, 64'(p), exp);
      step();
      c({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
      logic [63:0] lo_a, hi_a, lo_b, hi_b, mask;
      logic [63:0] q[$];
      int acc, cyc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      step(); step();
      rst_n = 1'b1;
      c("rst_in_ready", 64'(in_ready), 64'd1);
      c("rst_out_valid", 64'(out_valid), 64'd0);
      c("rst_p", 64'(p), 64'd0);
      c("rst_sub_a", 64'(sub_a), 64'd0);
      c("rst_sub_b", 64'(sub_b), 64'd0);

      // 0x12 * 0x21 with exact cycle-by-cycle sub-operand checks
      mask = (64'd1 << HH) - 64'd1;
      lo_a = 64'h12 & mask; hi_a = 64'h12 >> HH;
      lo_b = 64'h21 & mask; hi_b = 64'h21 >> HH;
      a = NN'(8'h12); b = NN'(8'h21); in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      c("c1_sub_a", 64'(sub_a), lo_a);
      c("c1_sub_b", 64'(sub_b), lo_b);
      c("c1_in_ready", 64'(in_ready), 64'd0);
      step();
      c("c2_sub_a", 64'(sub_a), hi_a);
      c("c2_sub_b", 64'(sub_b), hi_b);
      step();
      c("c3_sub_a", 64'(sub_a), lo_a ^ hi_a);
      c("c3_sub_b", 64'(sub_b), lo_b ^ hi_b);
      c("c3_out_valid", 64'(out_valid), 64'd0);
      step();
      c("c4_out_valid", 64'(out_valid), 64'd1);
      c("c4_p", 64'(p), 64'h0252);
      c("c4_sub_a", 64'(sub_a), 64'd0);
      c("c4_in_ready", 64'(in_ready), 64'd0);
      step();
      c("c5_in_ready", 64'(in_ready), 64'd1);
      c("c5_out_valid", 64'(out_valid), 64'd0);

      run_op(64'hFF, 64'hFF, 64'h5555, "ff_ff");
      run_op(64'h80, 64'h80, 64'h4000, "80_80");
      run_op(64'h03, 64'h03, 64'h0005, "03_03");
      run_op(64'h00, 64'hA5, 64'h0000, "00_a5");

      // backpressure: result held, in_valid pulses ignored
      a = NN'(8'h12); b = NN'(8'h21); in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      wait_out("bp");
      for (int i = 0; i < 6; i++) begin
        c("bp_hold_valid", 64'(out_valid), 64'd1);
        c("bp_hold_p", 64'(p), 64'h0252);
        c("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid = i[0];
        a = NN'($urandom); b = NN'($urandom);
        step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      c("bp_release_valid", 64'(out_valid), 64'd0);
      c("bp_release_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
        step();
        c("bp_no_extra", 64'(out_valid), 64'd0);
      end

      // reset while in HIGH discards the operation
      a = NN'(8'hFF); b = NN'(8'hFF); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      c("mrst_out_valid", 64'(out_valid), 64'd0);
      c("mrst_p", 64'(p), 64'd0);
      c("mrst_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
        step();
        c("mrst_no_stale", 64'(out_valid), 64'd0);
      end

      // randomized traffic against the reference queue
      acc = 0; cyc = 0;
      while ((acc < 200 || q.size() != 0 || out_valid) && cyc < 20000) begin
        in_valid  = (acc < 200) && ($urandom_range(0, 2) != 0);
        a         = NN'($urandom);
        b         = NN'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        c("rand_ready_valid_excl", 64'(in_ready & out_valid), 64'd0);
        if (in_valid && in_ready) begin
          q.push_back(clmul(64'(a), 64'(b), int'(NN)));
          acc++;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) c("rand_extra_result", 64'd1, 64'd0);
          else c("rand_p", 64'(p), q.pop_front());
        end
        step();
        cyc++;
      end
      c("rand_accepted", 64'(acc), 64'd200);
      c("rand_pending", 64'(q.size()), 64'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
      c("rand_idle", 64'(out_valid), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (gen_dut[0].fin && gen_dut[1].fin) break;
    end
    chk("completion", 64'(gen_dut[0].fin & gen_dut[1].fin), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
